// File: rtl/riscv_alu_main.sv
// riscv_alu_main: RV32I execute-stage integer ALU with registered outputs.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; outputs cleared and any same-cycle capture dropped
//   in_valid   operands valid; captured on this rising edge
//   a, b       operands (rs1/PC/zero and rs2/immediate)
//   funct3     operation select (ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND)
//   sub_sra    instruction bit 30: SUB for funct3=000, SRA for funct3=101
//   q          registered result, valid one cycle after capture
//   eq/lt/ltu  registered compare flags of a vs b, independent of funct3
//   out_valid  high for one cycle after each capture
module riscv_alu_main #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            funct3,
  input  logic                  sub_sra,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  eq,
  output logic                  lt,
  output logic                  ltu,
  output logic                  out_valid
);

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] result;
  logic                  eq_c;
  logic                  lt_c;
  logic                  ltu_c;

  assign shamt = b[4:0];

  // Flags are computed every cycle from a and b alone; SLT/SLTU reuse them.
  always_comb begin
    eq_c  = (a == b);
    lt_c  = ($signed(a) < $signed(b));
    ltu_c = (a < b);
  end

  always_comb begin
    result = '0;
    unique case (funct3)
      3'b000: result = sub_sra ? (a - b) : (a + b);
      3'b001: result = a << shamt;
      3'b010: result = {{(DATA_WIDTH-1){1'b0}}, lt_c};
      3'b011: result = {{(DATA_WIDTH-1){1'b0}}, ltu_c};
      3'b100: result = a ^ b;
      3'b101: result = sub_sra ? DATA_WIDTH'($signed(a) >>> shamt) : (a >> shamt);
      3'b110: result = a | b;
      3'b111: result = a & b;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= '0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      ltu       <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      q         <= result;
      eq        <= eq_c;
      lt        <= lt_c;
      ltu       <= ltu_c;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_alu_main.sv
module tb_riscv_alu_main;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  funct3;
  logic        sub_sra;
  logic [31:0] q;
  logic        eq;
  logic        lt;
  logic        ltu;
  logic        out_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the outputs should read after the latest edge.
  logic [31:0] exp_q   = '0;
  logic        exp_eq  = 1'b0;
  logic        exp_lt  = 1'b0;
  logic        exp_ltu = 1'b0;
  logic        exp_ov  = 1'b0;

  riscv_alu_main #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .funct3   (funct3),
    .sub_sra  (sub_sra),
    .q        (q),
    .eq       (eq),
    .lt       (lt),
    .ltu      (ltu),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Two's complement value of a 32-bit pattern as a wide integer.
  function automatic longint sval(input logic [31:0] x);
    return x[31] ? (longint'(x) - 64'sd4294967296) : longint'(x);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] f3, input logic ss);
    int unsigned s;
    logic [31:0] r;
    s = y % 32;
    case (f3)
      3'd0: r = ss ? x - y : x + y;
      3'd1: r = x << s;
      3'd2: r = (sval(x) < sval(y)) ? 32'd1 : 32'd0;
      3'd3: r = (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
      3'd4: r = x ^ y;
      3'd5: begin
        r = x >> s;
        if (ss && x[31]) r = r | ~(32'hFFFF_FFFF >> s);
      end
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  // Drive one cycle, advance past the edge, update the model and compare.
  task automatic step(input logic rst, input logic v, input logic [31:0] ia,
                      input logic [31:0] ib, input logic [2:0] f3, input logic ss);
    reset = rst; in_valid = v; a = ia; b = ib; funct3 = f3; sub_sra = ss;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q = '0; exp_eq = 0; exp_lt = 0; exp_ltu = 0; exp_ov = 0;
    end else if (v) begin
      exp_q   = ref_alu(ia, ib, f3, ss);
      exp_eq  = (ia == ib);
      exp_lt  = sval(ia) < sval(ib);
      exp_ltu = longint'(ia) < longint'(ib);
      exp_ov  = 1;
    end else begin
      exp_ov = 0;
    end
    check("q",         q,                {31'b0, 1'b0} | exp_q);
    check("eq",        {31'b0, eq},        {31'b0, exp_eq});
    check("lt",        {31'b0, lt},        {31'b0, exp_lt});
    check("ltu",       {31'b0, ltu},       {31'b0, exp_ltu});
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
  endtask

  logic [31:0] corners [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h1F, 32'h20, 32'h8000_0010};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    reset = 1; in_valid = 1; a = 5; b = 5; funct3 = 0; sub_sra = 0;

    // Reset dominates a simultaneous capture.
    step(1, 1, 5, 5, 3'd0, 0);
    step(1, 1, 5, 5, 3'd0, 0);
    check("rst_q", q, 32'h0);
    check("rst_ov", {31'b0, out_valid}, 32'h0);
    step(0, 1, 5, 5, 3'd0, 0);
    check("cap_eq", {31'b0, eq}, 32'h1);
    check("cap_ov", {31'b0, out_valid}, 32'h1);

    // Add/sub wrap.
    step(0, 1, 32'h7FFF_FFFF, 32'h1, 3'd0, 0);
    check("add_wrap", q, 32'h8000_0000);
    step(0, 1, 32'h0, 32'h1, 3'd0, 1);
    check("sub_wrap", q, 32'hFFFF_FFFF);
    check("sub_lt",  {31'b0, lt},  32'h1);
    check("sub_ltu", {31'b0, ltu}, 32'h1);

    // Shifts by 4 with upper b bits set.
    step(0, 1, 32'h8000_0010, 32'h24, 3'd1, 0);
    check("sll4", q, 32'h0000_0100);
    step(0, 1, 32'h8000_0010, 32'h24, 3'd5, 0);
    check("srl4", q, 32'h0800_0001);
    step(0, 1, 32'h8000_0010, 32'h24, 3'd5, 1);
    check("sra4", q, 32'hF800_0001);
    // Shift extremes.
    step(0, 1, 32'h8000_0000, 32'd31, 3'd5, 1);
    check("sra31", q, 32'hFFFF_FFFF);
    step(0, 1, 32'h8000_0000, 32'd31, 3'd5, 0);
    check("srl31", q, 32'h0000_0001);
    step(0, 1, 32'hDEAD_BEEF, 32'h40, 3'd1, 0);
    check("sll0", q, 32'hDEAD_BEEF);

    // Compares.
    step(0, 1, 32'hFFFF_FFFF, 32'h1, 3'd2, 0);
    check("slt", q, 32'h1);
    check("slt_lt", {31'b0, lt}, 32'h1);
    step(0, 1, 32'hFFFF_FFFF, 32'h1, 3'd3, 0);
    check("sltu", q, 32'h0);
    check("sltu_ltu", {31'b0, ltu}, 32'h0);
    check("sltu_eq",  {31'b0, eq},  32'h0);
    step(0, 1, 32'h8000_0000, 32'h0, 3'd4, 0);
    check("min_lt",  {31'b0, lt},  32'h1);
    check("min_ltu", {31'b0, ltu}, 32'h0);

    // Logic ops, sub_sra must not matter.
    for (int s = 0; s < 2; s++) begin
      step(0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, s[0]);
      check("xor", q, 32'h0FF0_0FF0);
      step(0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6, s[0]);
      check("or", q, 32'hFFF0_FFF0);
      step(0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, s[0]);
      check("and", q, 32'hF000_F000);
    end

    // Back-to-back then hold.
    step(0, 1, 32'd10, 32'd3, 3'd0, 0);
    check("stream0", q, 32'd13);
    step(0, 1, 32'd10, 32'd3, 3'd0, 1);
    check("stream1", q, 32'd7);
    step(0, 1, 32'd3, 32'd3, 3'd4, 0);
    check("stream2", q, 32'd0);
    step(0, 0, 32'd1, 32'd2, 3'd6, 1);
    check("hold_q",  q, 32'd0);
    check("hold_eq", {31'b0, eq}, 32'h1);
    check("hold_ov", {31'b0, out_valid}, 32'h0);
    step(0, 0, 32'd9, 32'd2, 3'd0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
           pick(), pick(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
